// File: rtl/axi_guard_pkg.sv
// Shared types and helpers for the AXI DDR window guard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_guard_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Outstanding-transaction counters are 4 bits, enough for MAX_OUTST = 15.
  localparam int CNT_W = 4;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_ERR  = 1'b1
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE     = 2'd0,
    W_ERR_DATA = 2'd1,
    W_ERR_RESP = 2'd2
  } w_state_e;

  // Only the start address is tested; bursts of 4 KiB or less never cross
  // a window of at least 4 KiB aligned to its own size.
  function automatic logic hit(input logic [31:0] addr,
                               input logic [31:0] base,
                               input int unsigned size_log2);
    logic [31:0] mask;
    mask = ~((32'h1 << size_log2) - 32'h1);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/axi_wroute_fifo.sv
// Small synchronous FIFO remembering, per accepted AW, where its W data goes.
// Latency: pushed entry is visible at the head the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; push+pop may coincide.
module axi_wroute_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem_q[rptr_q];

  // Next storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = push_dat;
      wptr_d        = wptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State register with synchronous reset to empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/axi_ddr_window_guard.sv
// AXI4 window guard: forwards in-window transactions, answers the rest locally with DECERR.
// Latency: zero on pass-through; DECERR R/B beats start the cycle after AR / W-last handshake.
// Backpressure: upstream ready follows downstream ready for hits; misses wait until the direction is drained.
module axi_ddr_window_guard
  import axi_guard_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'h8000_0000,
  parameter int unsigned SIZE_LOG2 = 27,
  parameter int unsigned MAX_OUTST = 15,
  parameter int unsigned WQ_DEPTH  = 4
) (
  input  logic        clock,
  input  logic        reset,
  // upstream AW
  input  logic        io_in_aw_valid,
  output logic        io_in_aw_ready,
  input  logic [3:0]  io_in_aw_id,
  input  logic [31:0] io_in_aw_addr,
  input  logic [7:0]  io_in_aw_len,
  input  logic [2:0]  io_in_aw_size,
  input  logic [1:0]  io_in_aw_burst,
  input  logic        io_in_aw_lock,
  input  logic [3:0]  io_in_aw_cache,
  input  logic [2:0]  io_in_aw_prot,
  input  logic [3:0]  io_in_aw_qos,
  // upstream W
  input  logic        io_in_w_valid,
  output logic        io_in_w_ready,
  input  logic [63:0] io_in_w_data,
  input  logic [7:0]  io_in_w_strb,
  input  logic        io_in_w_last,
  // upstream B
  output logic        io_in_b_valid,
  input  logic        io_in_b_ready,
  output logic [3:0]  io_in_b_id,
  output logic [1:0]  io_in_b_resp,
  // upstream AR
  input  logic        io_in_ar_valid,
  output logic        io_in_ar_ready,
  input  logic [3:0]  io_in_ar_id,
  input  logic [31:0] io_in_ar_addr,
  input  logic [7:0]  io_in_ar_len,
  input  logic [2:0]  io_in_ar_size,
  input  logic [1:0]  io_in_ar_burst,
  input  logic        io_in_ar_lock,
  input  logic [3:0]  io_in_ar_cache,
  input  logic [2:0]  io_in_ar_prot,
  input  logic [3:0]  io_in_ar_qos,
  // upstream R
  output logic        io_in_r_valid,
  input  logic        io_in_r_ready,
  output logic [3:0]  io_in_r_id,
  output logic [63:0] io_in_r_data,
  output logic [1:0]  io_in_r_resp,
  output logic        io_in_r_last,
  // downstream AW
  output logic        io_out_aw_valid,
  input  logic        io_out_aw_ready,
  output logic [3:0]  io_out_aw_id,
  output logic [31:0] io_out_aw_addr,
  output logic [7:0]  io_out_aw_len,
  output logic [2:0]  io_out_aw_size,
  output logic [1:0]  io_out_aw_burst,
  output logic        io_out_aw_lock,
  output logic [3:0]  io_out_aw_cache,
  output logic [2:0]  io_out_aw_prot,
  output logic [3:0]  io_out_aw_qos,
  // downstream W
  output logic        io_out_w_valid,
  input  logic        io_out_w_ready,
  output logic [63:0] io_out_w_data,
  output logic [7:0]  io_out_w_strb,
  output logic        io_out_w_last,
  // downstream B
  input  logic        io_out_b_valid,
  output logic        io_out_b_ready,
  input  logic [3:0]  io_out_b_id,
  input  logic [1:0]  io_out_b_resp,
  // downstream AR
  output logic        io_out_ar_valid,
  input  logic        io_out_ar_ready,
  output logic [3:0]  io_out_ar_id,
  output logic [31:0] io_out_ar_addr,
  output logic [7:0]  io_out_ar_len,
  output logic [2:0]  io_out_ar_size,
  output logic [1:0]  io_out_ar_burst,
  output logic        io_out_ar_lock,
  output logic [3:0]  io_out_ar_cache,
  output logic [2:0]  io_out_ar_prot,
  output logic [3:0]  io_out_ar_qos,
  // downstream R
  input  logic        io_out_r_valid,
  output logic        io_out_r_ready,
  input  logic [3:0]  io_out_r_id,
  input  logic [63:0] io_out_r_data,
  input  logic [1:0]  io_out_r_resp,
  input  logic        io_out_r_last
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

  // ---------------- read path state ----------------
  r_state_e          r_state_q, r_state_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [3:0]        r_id_q, r_id_d;
  logic [7:0]        r_len_q, r_len_d;
  logic [7:0]        r_beat_q, r_beat_d;
  logic              ar_hit, ar_room, ar_miss_acc, out_ar_hs, out_r_last_hs, in_r_hs;

  // ---------------- write path state ---------------
  w_state_e          w_state_q, w_state_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [3:0]        w_id_q, w_id_d;
  logic              aw_hit, aw_room, aw_acc, out_aw_hs, out_b_hs, in_b_hs;
  logic              wq_push, wq_pop, wq_head, wq_full, wq_empty;

  assign ar_hit  = hit(io_in_ar_addr, BASE, SIZE_LOG2);
  assign aw_hit  = hit(io_in_aw_addr, BASE, SIZE_LOG2);
  assign ar_room = (rd_cnt_q < CNT_MAX);
  assign aw_room = (wr_cnt_q < CNT_MAX);

  // Request fields are forwarded untouched; only the valids are gated.
  assign io_out_ar_id    = io_in_ar_id;
  assign io_out_ar_addr  = io_in_ar_addr;
  assign io_out_ar_len   = io_in_ar_len;
  assign io_out_ar_size  = io_in_ar_size;
  assign io_out_ar_burst = io_in_ar_burst;
  assign io_out_ar_lock  = io_in_ar_lock;
  assign io_out_ar_cache = io_in_ar_cache;
  assign io_out_ar_prot  = io_in_ar_prot;
  assign io_out_ar_qos   = io_in_ar_qos;
  assign io_out_aw_id    = io_in_aw_id;
  assign io_out_aw_addr  = io_in_aw_addr;
  assign io_out_aw_len   = io_in_aw_len;
  assign io_out_aw_size  = io_in_aw_size;
  assign io_out_aw_burst = io_in_aw_burst;
  assign io_out_aw_lock  = io_in_aw_lock;
  assign io_out_aw_cache = io_in_aw_cache;
  assign io_out_aw_prot  = io_in_aw_prot;
  assign io_out_aw_qos   = io_in_aw_qos;
  assign io_out_w_data   = io_in_w_data;
  assign io_out_w_strb   = io_in_w_strb;
  assign io_out_w_last   = io_in_w_last;

  assign out_ar_hs     = io_out_ar_valid & io_out_ar_ready;
  assign out_r_last_hs = io_out_r_valid & io_out_r_ready & io_out_r_last;
  assign in_r_hs       = io_in_r_valid & io_in_r_ready;
  assign ar_miss_acc   = io_in_ar_valid & io_in_ar_ready & ~ar_hit;

  assign out_aw_hs = io_out_aw_valid & io_out_aw_ready;
  assign out_b_hs  = io_out_b_valid & io_out_b_ready;
  assign in_b_hs   = io_in_b_valid & io_in_b_ready;
  assign aw_acc    = io_in_aw_valid & io_in_aw_ready;
  assign wq_push   = aw_acc;
  assign wq_pop    = io_in_w_valid & io_in_w_ready & io_in_w_last;

  // One routing bit per accepted AW: 1 means its W beats are sunk locally.
  axi_wroute_fifo #(
    .DEPTH (WQ_DEPTH),
    .WIDTH (1)
  ) u_wroute (
    .clock    (clock),
    .reset    (reset),
    .push     (wq_push),
    .push_dat (~aw_hit),
    .pop      (wq_pop),
    .pop_dat  (wq_head),
    .full     (wq_full),
    .empty    (wq_empty)
  );

  // State register for both directions.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      rd_cnt_q  <= '0;
      r_id_q    <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      w_state_q <= W_IDLE;
      wr_cnt_q  <= '0;
      w_id_q    <= '0;
    end else begin
      r_state_q <= r_state_d;
      rd_cnt_q  <= rd_cnt_d;
      r_id_q    <= r_id_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      w_state_q <= w_state_d;
      wr_cnt_q  <= wr_cnt_d;
      w_id_q    <= w_id_d;
    end
  end

  // Read next-state: latch a miss and walk its DECERR beats; track forwarded reads.
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    rd_cnt_d  = rd_cnt_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_miss_acc) begin
          r_state_d = R_ERR;
          r_id_d    = io_in_ar_id;
          r_len_d   = io_in_ar_len;
          r_beat_d  = '0;
        end
      end
      R_ERR: begin
        if (in_r_hs) begin
          if (io_in_r_last) r_state_d = R_IDLE;
          else              r_beat_d  = r_beat_q + 8'd1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    case ({out_ar_hs, out_r_last_hs})
      2'b10:   rd_cnt_d = rd_cnt_q + CNT_W'(1);
      2'b01:   rd_cnt_d = rd_cnt_q - CNT_W'(1);
      default: rd_cnt_d = rd_cnt_q;
    endcase
  end

  // Read outputs: AR gating and the R mux between downstream and the DECERR generator.
  always_comb begin
    io_out_ar_valid = 1'b0;
    io_in_ar_ready  = 1'b0;
    io_in_r_valid   = io_out_r_valid;
    io_in_r_id      = io_out_r_id;
    io_in_r_data    = io_out_r_data;
    io_in_r_resp    = io_out_r_resp;
    io_in_r_last    = io_out_r_last;
    io_out_r_ready  = io_in_r_ready;
    if ((r_state_q == R_IDLE) && io_in_ar_valid) begin
      if (ar_hit) begin
        io_out_ar_valid = ar_room;
        io_in_ar_ready  = io_out_ar_ready & ar_room;
      end else begin
        io_in_ar_ready  = (rd_cnt_q == '0);
      end
    end
    if (r_state_q == R_ERR) begin
      io_in_r_valid  = 1'b1;
      io_in_r_id     = r_id_q;
      io_in_r_data   = '0;
      io_in_r_resp   = RESP_DECERR;
      io_in_r_last   = (r_beat_q == r_len_q);
      io_out_r_ready = 1'b0;
    end
  end

  // Write next-state: miss AW -> sink its data -> local B; track forwarded writes.
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    wr_cnt_d  = wr_cnt_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_acc && !aw_hit) begin
          w_state_d = W_ERR_DATA;
          w_id_d    = io_in_aw_id;
        end
      end
      W_ERR_DATA: begin
        if (wq_pop && wq_head) w_state_d = W_ERR_RESP;
      end
      W_ERR_RESP: begin
        if (in_b_hs) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    case ({out_aw_hs, out_b_hs})
      2'b10:   wr_cnt_d = wr_cnt_q + CNT_W'(1);
      2'b01:   wr_cnt_d = wr_cnt_q - CNT_W'(1);
      default: wr_cnt_d = wr_cnt_q;
    endcase
  end

  // Write outputs: AW gating, W routing from the queue head, B mux.
  always_comb begin
    io_out_aw_valid = 1'b0;
    io_in_aw_ready  = 1'b0;
    io_out_w_valid  = 1'b0;
    io_in_w_ready   = 1'b0;
    io_in_b_valid   = io_out_b_valid;
    io_in_b_id      = io_out_b_id;
    io_in_b_resp    = io_out_b_resp;
    io_out_b_ready  = io_in_b_ready;
    if ((w_state_q == W_IDLE) && io_in_aw_valid && !wq_full) begin
      if (aw_hit) begin
        io_out_aw_valid = aw_room;
        io_in_aw_ready  = io_out_aw_ready & aw_room;
      end else begin
        io_in_aw_ready  = (wr_cnt_q == '0);
      end
    end
    if (!wq_empty) begin
      if (wq_head) begin
        io_in_w_ready  = 1'b1;
      end else begin
        io_out_w_valid = io_in_w_valid;
        io_in_w_ready  = io_out_w_ready;
      end
    end
    if (w_state_q == W_ERR_RESP) begin
      io_in_b_valid  = 1'b1;
      io_in_b_id     = w_id_q;
      io_in_b_resp   = RESP_DECERR;
      io_out_b_ready = 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_ddr_window_guard.sv
// Directed and randomized bench for the AXI DDR window guard.
// Latency: checks same-cycle pass-through and next-cycle DECERR responses.
// Backpressure: exercises stalled readies, outstanding-count and queue-full stalls.
module tb_axi_ddr_window_guard;

  localparam logic [31:0] BASE      = 32'h8000_0000;
  localparam int          SIZE_LOG2 = 27;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        io_in_aw_valid, io_in_aw_ready;
  logic [3:0]  io_in_aw_id;
  logic [31:0] io_in_aw_addr;
  logic [7:0]  io_in_aw_len;
  logic [2:0]  io_in_aw_size;
  logic [1:0]  io_in_aw_burst;
  logic        io_in_aw_lock;
  logic [3:0]  io_in_aw_cache;
  logic [2:0]  io_in_aw_prot;
  logic [3:0]  io_in_aw_qos;
  logic        io_in_w_valid, io_in_w_ready;
  logic [63:0] io_in_w_data;
  logic [7:0]  io_in_w_strb;
  logic        io_in_w_last;
  logic        io_in_b_valid, io_in_b_ready;
  logic [3:0]  io_in_b_id;
  logic [1:0]  io_in_b_resp;
  logic        io_in_ar_valid, io_in_ar_ready;
  logic [3:0]  io_in_ar_id;
  logic [31:0] io_in_ar_addr;
  logic [7:0]  io_in_ar_len;
  logic [2:0]  io_in_ar_size;
  logic [1:0]  io_in_ar_burst;
  logic        io_in_ar_lock;
  logic [3:0]  io_in_ar_cache;
  logic [2:0]  io_in_ar_prot;
  logic [3:0]  io_in_ar_qos;
  logic        io_in_r_valid, io_in_r_ready;
  logic [3:0]  io_in_r_id;
  logic [63:0] io_in_r_data;
  logic [1:0]  io_in_r_resp;
  logic        io_in_r_last;
  logic        io_out_aw_valid, io_out_aw_ready;
  logic [3:0]  io_out_aw_id;
  logic [31:0] io_out_aw_addr;
  logic [7:0]  io_out_aw_len;
  logic [2:0]  io_out_aw_size;
  logic [1:0]  io_out_aw_burst;
  logic        io_out_aw_lock;
  logic [3:0]  io_out_aw_cache;
  logic [2:0]  io_out_aw_prot;
  logic [3:0]  io_out_aw_qos;
  logic        io_out_w_valid, io_out_w_ready;
  logic [63:0] io_out_w_data;
  logic [7:0]  io_out_w_strb;
  logic        io_out_w_last;
  logic        io_out_b_valid, io_out_b_ready;
  logic [3:0]  io_out_b_id;
  logic [1:0]  io_out_b_resp;
  logic        io_out_ar_valid, io_out_ar_ready;
  logic [3:0]  io_out_ar_id;
  logic [31:0] io_out_ar_addr;
  logic [7:0]  io_out_ar_len;
  logic [2:0]  io_out_ar_size;
  logic [1:0]  io_out_ar_burst;
  logic        io_out_ar_lock;
  logic [3:0]  io_out_ar_cache;
  logic [2:0]  io_out_ar_prot;
  logic [3:0]  io_out_ar_qos;
  logic        io_out_r_valid, io_out_r_ready;
  logic [3:0]  io_out_r_id;
  logic [63:0] io_out_r_data;
  logic [1:0]  io_out_r_resp;
  logic        io_out_r_last;

  int n_cmp  = 0;
  int n_fail = 0;

  axi_ddr_window_guard dut (
    .clock(clock), .reset(reset),
    .io_in_aw_valid(io_in_aw_valid), .io_in_aw_ready(io_in_aw_ready), .io_in_aw_id(io_in_aw_id),
    .io_in_aw_addr(io_in_aw_addr), .io_in_aw_len(io_in_aw_len), .io_in_aw_size(io_in_aw_size),
    .io_in_aw_burst(io_in_aw_burst), .io_in_aw_lock(io_in_aw_lock), .io_in_aw_cache(io_in_aw_cache),
    .io_in_aw_prot(io_in_aw_prot), .io_in_aw_qos(io_in_aw_qos),
    .io_in_w_valid(io_in_w_valid), .io_in_w_ready(io_in_w_ready), .io_in_w_data(io_in_w_data),
    .io_in_w_strb(io_in_w_strb), .io_in_w_last(io_in_w_last),
    .io_in_b_valid(io_in_b_valid), .io_in_b_ready(io_in_b_ready), .io_in_b_id(io_in_b_id),
    .io_in_b_resp(io_in_b_resp),
    .io_in_ar_valid(io_in_ar_valid), .io_in_ar_ready(io_in_ar_ready), .io_in_ar_id(io_in_ar_id),
    .io_in_ar_addr(io_in_ar_addr), .io_in_ar_len(io_in_ar_len), .io_in_ar_size(io_in_ar_size),
    .io_in_ar_burst(io_in_ar_burst), .io_in_ar_lock(io_in_ar_lock), .io_in_ar_cache(io_in_ar_cache),
    .io_in_ar_prot(io_in_ar_prot), .io_in_ar_qos(io_in_ar_qos),
    .io_in_r_valid(io_in_r_valid), .io_in_r_ready(io_in_r_ready), .io_in_r_id(io_in_r_id),
    .io_in_r_data(io_in_r_data), .io_in_r_resp(io_in_r_resp), .io_in_r_last(io_in_r_last),
    .io_out_aw_valid(io_out_aw_valid), .io_out_aw_ready(io_out_aw_ready), .io_out_aw_id(io_out_aw_id),
    .io_out_aw_addr(io_out_aw_addr), .io_out_aw_len(io_out_aw_len), .io_out_aw_size(io_out_aw_size),
    .io_out_aw_burst(io_out_aw_burst), .io_out_aw_lock(io_out_aw_lock), .io_out_aw_cache(io_out_aw_cache),
    .io_out_aw_prot(io_out_aw_prot), .io_out_aw_qos(io_out_aw_qos),
    .io_out_w_valid(io_out_w_valid), .io_out_w_ready(io_out_w_ready), .io_out_w_data(io_out_w_data),
    .io_out_w_strb(io_out_w_strb), .io_out_w_last(io_out_w_last),
    .io_out_b_valid(io_out_b_valid), .io_out_b_ready(io_out_b_ready), .io_out_b_id(io_out_b_id),
    .io_out_b_resp(io_out_b_resp),
    .io_out_ar_valid(io_out_ar_valid), .io_out_ar_ready(io_out_ar_ready), .io_out_ar_id(io_out_ar_id),
    .io_out_ar_addr(io_out_ar_addr), .io_out_ar_len(io_out_ar_len), .io_out_ar_size(io_out_ar_size),
    .io_out_ar_burst(io_out_ar_burst), .io_out_ar_lock(io_out_ar_lock), .io_out_ar_cache(io_out_ar_cache),
    .io_out_ar_prot(io_out_ar_prot), .io_out_ar_qos(io_out_ar_qos),
    .io_out_r_valid(io_out_r_valid), .io_out_r_ready(io_out_r_ready), .io_out_r_id(io_out_r_id),
    .io_out_r_data(io_out_r_data), .io_out_r_resp(io_out_r_resp), .io_out_r_last(io_out_r_last)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference window rule: the address lies in the window when its bits above
  // SIZE_LOG2 equal those of BASE.
  function automatic bit model_hit(input logic [31:0] a);
    return (a >> SIZE_LOG2) == (BASE >> SIZE_LOG2);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    io_in_aw_valid = 0; io_in_w_valid = 0; io_in_ar_valid = 0;
    io_in_b_ready = 0; io_in_r_ready = 0;
    io_out_b_valid = 0; io_out_r_valid = 0;
    io_out_ar_ready = 1; io_out_aw_ready = 1; io_out_w_ready = 1;
    io_in_aw_id = 0; io_in_aw_addr = 0; io_in_aw_len = 0; io_in_aw_size = 3; io_in_aw_burst = 1;
    io_in_aw_lock = 0; io_in_aw_cache = 0; io_in_aw_prot = 0; io_in_aw_qos = 0;
    io_in_ar_id = 0; io_in_ar_addr = 0; io_in_ar_len = 0; io_in_ar_size = 3; io_in_ar_burst = 1;
    io_in_ar_lock = 0; io_in_ar_cache = 0; io_in_ar_prot = 0; io_in_ar_qos = 0;
    io_in_w_data = 0; io_in_w_strb = 0; io_in_w_last = 0;
    io_out_b_id = 0; io_out_b_resp = 0;
    io_out_r_id = 0; io_out_r_data = 0; io_out_r_resp = 0; io_out_r_last = 0;
  endtask

  task automatic drive_ar(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    io_in_ar_valid = 1; io_in_ar_addr = addr; io_in_ar_len = len; io_in_ar_id = id;
    io_in_ar_size = 3'($urandom); io_in_ar_burst = 2'($urandom); io_in_ar_lock = 1'($urandom);
    io_in_ar_cache = 4'($urandom); io_in_ar_prot = 3'($urandom); io_in_ar_qos = 4'($urandom);
  endtask

  task automatic drive_aw(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    io_in_aw_valid = 1; io_in_aw_addr = addr; io_in_aw_len = len; io_in_aw_id = id;
    io_in_aw_size = 3'($urandom); io_in_aw_burst = 2'($urandom); io_in_aw_lock = 1'($urandom);
    io_in_aw_cache = 4'($urandom); io_in_aw_prot = 3'($urandom); io_in_aw_qos = 4'($urandom);
  endtask

  // Downstream returns len+1 beats; upstream must see each one unchanged.
  task automatic hit_beats(input logic [7:0] len, input logic [3:0] id);
    logic [63:0] d;
    for (int b = 0; b <= int'(len); b++) begin
      d = {$urandom, $urandom};
      io_out_r_valid = 1; io_out_r_id = id; io_out_r_data = d;
      io_out_r_resp = 2'b00; io_out_r_last = (b == int'(len));
      for (int t = 0; t < 4; t++) begin
        io_in_r_ready = (t == 3) ? 1'b1 : 1'($urandom_range(0, 1));
        settle();
        check("r_pass_valid", 64'(io_in_r_valid), 64'd1);
        check("r_pass_data", io_in_r_data, d);
        check("r_pass_id", 64'(io_in_r_id), 64'(id));
        check("r_pass_last", 64'(io_in_r_last), 64'(b == int'(len)));
        check("r_pass_ready", 64'(io_out_r_ready), 64'(io_in_r_ready));
        tick();
        if (io_in_r_ready) break;
      end
    end
    io_out_r_valid = 0; io_in_r_ready = 0;
  endtask

  // Locally generated DECERR burst of len+1 beats.
  task automatic err_beats(input logic [7:0] len, input logic [3:0] id);
    for (int b = 0; b <= int'(len); b++) begin
      for (int t = 0; t < 4; t++) begin
        io_in_r_ready = (t == 3) ? 1'b1 : 1'($urandom_range(0, 1));
        settle();
        check("err_r_valid", 64'(io_in_r_valid), 64'd1);
        check("err_r_data", io_in_r_data, 64'd0);
        check("err_r_resp", 64'(io_in_r_resp), 64'd3);
        check("err_r_id", 64'(io_in_r_id), 64'(id));
        check("err_r_last", 64'(io_in_r_last), 64'(b == int'(len)));
        check("err_out_r_ready", 64'(io_out_r_ready), 64'd0);
        check("err_no_out_ar", 64'(io_out_ar_valid), 64'd0);
        tick();
        if (io_in_r_ready) break;
      end
    end
    io_in_r_ready = 0;
    settle();
    check("err_r_done", 64'(io_in_r_valid), 64'd0);
    tick();
  endtask

  task automatic run_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    bit h;
    h = model_hit(addr);
    drive_ar(addr, len, id);
    io_out_ar_ready = 1;
    settle();
    if (h) begin
      check("ar_fwd_valid", 64'(io_out_ar_valid), 64'd1);
      check("ar_fwd_addr", 64'(io_out_ar_addr), 64'(addr));
      check("ar_fwd_len_id", 64'({io_out_ar_len, io_out_ar_id}), 64'({len, id}));
      check("ar_fwd_attr", 64'({io_out_ar_size, io_out_ar_burst, io_out_ar_lock, io_out_ar_cache,
                                io_out_ar_prot, io_out_ar_qos}),
            64'({io_in_ar_size, io_in_ar_burst, io_in_ar_lock, io_in_ar_cache, io_in_ar_prot, io_in_ar_qos}));
      check("ar_hit_ready", 64'(io_in_ar_ready), 64'd1);
    end else begin
      check("ar_miss_no_fwd", 64'(io_out_ar_valid), 64'd0);
      check("ar_miss_ready", 64'(io_in_ar_ready), 64'd1);
    end
    tick();
    io_in_ar_valid = 0;
    if (h) hit_beats(len, id);
    else   err_beats(len, id);
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    bit h;
    logic [63:0] d;
    logic [7:0]  s;
    h = model_hit(addr);
    drive_aw(addr, len, id);
    io_out_aw_ready = 1;
    settle();
    if (h) begin
      check("aw_fwd_valid", 64'(io_out_aw_valid), 64'd1);
      check("aw_fwd_addr", 64'(io_out_aw_addr), 64'(addr));
      check("aw_fwd_len_id", 64'({io_out_aw_len, io_out_aw_id}), 64'({len, id}));
      check("aw_fwd_attr", 64'({io_out_aw_size, io_out_aw_burst, io_out_aw_lock, io_out_aw_cache,
                                io_out_aw_prot, io_out_aw_qos}),
            64'({io_in_aw_size, io_in_aw_burst, io_in_aw_lock, io_in_aw_cache, io_in_aw_prot, io_in_aw_qos}));
      check("aw_hit_ready", 64'(io_in_aw_ready), 64'd1);
    end else begin
      check("aw_miss_no_fwd", 64'(io_out_aw_valid), 64'd0);
      check("aw_miss_ready", 64'(io_in_aw_ready), 64'd1);
    end
    tick();
    io_in_aw_valid = 0;
    for (int b = 0; b <= int'(len); b++) begin
      d = {$urandom, $urandom};
      s = 8'($urandom);
      io_in_w_valid = 1; io_in_w_data = d; io_in_w_strb = s; io_in_w_last = (b == int'(len));
      for (int t = 0; t < 4; t++) begin
        io_out_w_ready = (t == 3) ? 1'b1 : 1'($urandom_range(0, 1));
        settle();
        if (h) begin
          check("w_pass_valid", 64'(io_out_w_valid), 64'd1);
          check("w_pass_data", io_out_w_data, d);
          check("w_pass_strb_last", 64'({io_out_w_strb, io_out_w_last}), 64'({s, io_in_w_last}));
          check("w_pass_ready", 64'(io_in_w_ready), 64'(io_out_w_ready));
        end else begin
          check("w_sink_no_fwd", 64'(io_out_w_valid), 64'd0);
          check("w_sink_ready", 64'(io_in_w_ready), 64'd1);
        end
        tick();
        if (!h || io_out_w_ready) break;
      end
    end
    io_in_w_valid = 0; io_out_w_ready = 1;
    if (h) begin
      io_out_b_valid = 1; io_out_b_id = id; io_out_b_resp = 2'b00; io_in_b_ready = 1;
      settle();
      check("b_pass_valid", 64'(io_in_b_valid), 64'd1);
      check("b_pass_id_resp", 64'({io_in_b_id, io_in_b_resp}), 64'({id, 2'b00}));
      check("b_pass_ready", 64'(io_out_b_ready), 64'd1);
      tick();
      io_out_b_valid = 0; io_in_b_ready = 0;
    end else begin
      // B is held back one cycle while a hit AW tries to sneak in.
      drive_aw(BASE | 32'h0000_2000, 8'd0, 4'd1);
      io_in_b_ready = 0;
      settle();
      check("err_b_valid", 64'(io_in_b_valid), 64'd1);
      check("err_b_id_resp", 64'({io_in_b_id, io_in_b_resp}), 64'({id, 2'b11}));
      check("err_b_out_ready", 64'(io_out_b_ready), 64'd0);
      check("aw_blocked_in_resp", 64'({io_in_aw_ready, io_out_aw_valid}), 64'd0);
      tick();
      io_in_aw_valid = 0; io_in_b_ready = 1;
      settle();
      check("err_b_hold", 64'(io_in_b_valid), 64'd1);
      tick();
      io_in_b_ready = 0;
      settle();
      check("err_b_done", 64'(io_in_b_valid), 64'd0);
      tick();
    end
  endtask

  logic [31:0] ra;

  initial begin
    clear_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;

    // Reset state: no valids anywhere, no upstream ready without a request.
    settle();
    check("rst_in_ar_ready", 64'(io_in_ar_ready), 64'd0);
    check("rst_in_aw_ready", 64'(io_in_aw_ready), 64'd0);
    check("rst_in_w_ready", 64'(io_in_w_ready), 64'd0);
    check("rst_in_r_b_valid", 64'({io_in_r_valid, io_in_b_valid}), 64'd0);
    check("rst_out_valids", 64'({io_out_ar_valid, io_out_aw_valid, io_out_w_valid}), 64'd0);
    tick();

    // Hit read, then miss read.
    run_read(32'h8000_1000, 8'd7, 4'd3);
    run_read(32'h1000_0000, 8'd3, 4'd5);

    // Two hit reads outstanding, then a miss AR that must wait for both R-lasts.
    drive_ar(BASE | 32'h100, 8'd0, 4'd1);
    settle(); check("two_out_ar1", 64'(io_out_ar_valid), 64'd1); tick();
    drive_ar(BASE | 32'h200, 8'd0, 4'd2);
    settle(); check("two_out_ar2", 64'(io_out_ar_valid), 64'd1); tick();
    drive_ar(32'h1000_0000, 8'd3, 4'd7);
    io_out_r_valid = 1; io_out_r_id = 1; io_out_r_last = 1; io_out_r_data = 64'h11; io_in_r_ready = 1;
    settle();
    check("miss_stall_cnt2", 64'({io_in_ar_ready, io_out_ar_valid}), 64'd0);
    tick();
    io_out_r_id = 2;
    settle();
    check("miss_stall_cnt1", 64'({io_in_ar_ready, io_out_ar_valid}), 64'd0);
    tick();
    io_out_r_valid = 0; io_in_r_ready = 0;
    settle();
    check("miss_release", 64'(io_in_ar_ready), 64'd1);
    tick();
    io_in_ar_valid = 0;
    err_beats(8'd3, 4'd7);

    // Miss write len=1 id=2.
    run_write(32'h1000_0000, 8'd1, 4'd2);

    // Queue full: four hit AWs with no W, fifth stalls until the first pop.
    io_out_aw_ready = 1; io_out_w_ready = 1;
    for (int i = 0; i < 4; i++) begin
      drive_aw(BASE | (32'(i) << 12), 8'd0, 4'(i));
      settle();
      check("qfill_aw_ready", 64'(io_in_aw_ready), 64'd1);
      tick();
    end
    drive_aw(BASE | 32'h4000, 8'd0, 4'd4);
    settle();
    check("qfull_aw_stall", 64'({io_in_aw_ready, io_out_aw_valid}), 64'd0);
    tick();
    io_in_w_valid = 1; io_in_w_last = 1; io_in_w_data = 64'hA5; io_in_w_strb = 8'hFF;
    settle();
    check("qfull_stall_at_pop", 64'(io_in_aw_ready), 64'd0);
    check("qfull_w_fwd", 64'(io_out_w_valid), 64'd1);
    tick();
    settle();
    check("qfull_aw5_accept", 64'({io_in_aw_ready, io_out_aw_valid}), 64'b11);
    tick();
    io_in_aw_valid = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("qdrain_w_fwd", 64'(io_out_w_valid), 64'd1);
      tick();
    end
    io_in_w_valid = 0;
    settle();
    check("qempty_w_ready", 64'(io_in_w_ready), 64'd0);
    tick();
    io_in_b_ready = 1;
    for (int i = 0; i < 5; i++) begin
      io_out_b_valid = 1; io_out_b_id = 4'(i); io_out_b_resp = 2'b00;
      settle();
      check("qdrain_b", 64'({io_in_b_valid, io_in_b_id}), 64'({1'b1, 4'(i)}));
      tick();
    end
    io_out_b_valid = 0; io_in_b_ready = 0;

    // Reset during the second DECERR beat abandons the burst.
    drive_ar(32'h2000_0000, 8'd3, 4'd9);
    settle(); check("rst_burst_ar", 64'(io_in_ar_ready), 64'd1); tick();
    io_in_ar_valid = 0; io_in_r_ready = 1;
    settle(); check("rst_burst_beat1", 64'(io_in_r_valid), 64'd1); tick();
    io_in_r_ready = 0; reset = 1;
    settle(); check("rst_burst_beat2", 64'({io_in_r_valid, io_in_r_last}), 64'b10); tick();
    reset = 0;
    settle(); check("rst_burst_gone", 64'(io_in_r_valid), 64'd0); tick();
    run_read(BASE | 32'h3000, 8'd2, 4'd3);

    // Randomized single-transaction traffic against the window rule.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) ra = BASE | ($urandom & 32'h07FF_F000);
      else                           ra = $urandom;
      if ($urandom_range(0, 1) == 1) run_read(ra, 8'($urandom_range(0, 7)), 4'($urandom));
      else                           run_write(ra, 8'($urandom_range(0, 7)), 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_ddr_window_guard.md
# axi_ddr_window_guard

AXI4 address-window guard between the Rocket memory port and the DDR path (`AXIMem`), in the `clock` domain. In-range transactions pass through. Out-of-range reads and writes are terminated locally with DECERR, so a stray access cannot reach the MIG or hang the core. Upstream (`io_in_*`) is the AXI4 master side; downstream (`io_out_*`) feeds the DDR path.

## Interface
- `BASE`, `32'h8000_0000`: window base; must be aligned to 2^`SIZE_LOG2`.
- `SIZE_LOG2`, `27`: window size is 2^`SIZE_LOG2` bytes; must be ≥ 12.
- `MAX_OUTST`, `15`: max forwarded transactions outstanding per direction; counters are 4 bits wide.
- `WQ_DEPTH`, `4`: depth of the W-routing queue; power of two.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `io_in_aw_*` / `io_out_aw_*`:
  - direction: in / out, except `ready`, which is the reverse.
  - fields: valid, ready, id[3:0], addr[31:0], len[7:0], size[2:0], burst[1:0], lock, cache[3:0], prot[2:0], qos[3:0].
- `io_in_w_*` / `io_out_w_*`: valid, ready, data[63:0], strb[7:0], last. Same direction rule.
- `io_in_b_*` / `io_out_b_*`: valid, ready, id[3:0], resp[1:0]. Upstream side is out, except `ready`.
- `io_in_ar_*` / `io_out_ar_*`: same fields as AW.
- `io_in_r_*` / `io_out_r_*`: valid, ready, id[3:0], data[63:0], resp[1:0], last.

## Operation
- **Window test:** `hit = (addr & ~(2^SIZE_LOG2-1)) == BASE`. Only the start address is checked; a burst of 4 KiB or less cannot cross the window. Address and all other fields are forwarded unmodified.
- **Read path:** FSM R_IDLE / R_ERR, plus counter `rd_cnt`.
  - Hit AR: `io_out_ar_valid = io_in_ar_valid & R_IDLE & rd_cnt<MAX_OUTST`.
  - Hit AR ready: `io_in_ar_ready = io_out_ar_ready` under the same gate.
  - `rd_cnt` increments on each downstream AR handshake and decrements on each downstream R handshake with last. Simultaneous increment and decrement leaves it unchanged.
  - Miss AR: accepted only when R_IDLE and `rd_cnt==0`. On accept, latch id and len, then go to R_ERR. Until accepted, `io_in_ar_ready=0` and nothing is forwarded.
  - R_ERR emits len+1 beats: `r_data=0`, `r_resp=2'b11`, latched id, `last` on the final beat. It returns to R_IDLE on the last handshake.
  - While in R_ERR, the R mux selects the local generator and `io_out_r_ready=0`. Otherwise R passes straight through.
- **Write path:** FSM W_IDLE / W_ERR_DATA / W_ERR_RESP, plus counter `wr_cnt` and the W-routing queue (1 bit per entry, `err`).
  - Hit AW: forwarded when W_IDLE, queue not full, and `wr_cnt<MAX_OUTST`. Push `err=0` on the handshake.
  - Miss AW: accepted when W_IDLE, `wr_cnt==0`, and queue not full. Push `err=1`, latch id, go to W_ERR_DATA.
  - No AW is accepted outside W_IDLE.
  - W routing:
    - Queue empty: `io_in_w_ready=0` and `io_out_w_valid=0`.
    - Head `err=0`: W passes through.
    - Head `err=1`: W is sunk (`io_in_w_ready=1`, `io_out_w_valid=0`).
    - The head is popped on a W handshake with last.
  - Popping an `err` entry moves W_ERR_DATA to W_ERR_RESP.
  - W_ERR_RESP drives `io_in_b_valid=1`, `resp=2'b11`, latched id, and returns to W_IDLE on the handshake.
  - Otherwise B passes through. `wr_cnt` increments on downstream AW handshake and decrements on downstream B handshake.
- **Ordering:** error responses are issued only with zero downstream transactions outstanding in that direction, and new requests are blocked until they finish. This keeps per-ID ordering intact.
- **Reset:**
  - FSMs go to idle, counters to 0, queue to empty.
  - All upstream and downstream valids are 0.
  - Upstream readies evaluate to 0 until a request is presented.
  - Reset mid-burst abandons the burst without emitting further beats.

## Timing
- Pass-through is combinational on every channel: zero added latency. Ready may depend on valid and on addr, but valid never depends on ready.
- Error read: first DECERR beat is valid the cycle after the AR handshake; one beat per cycle while `r_ready=1`.
- Error write: B valid the cycle after the W-last handshake.
- A miss AR arriving with `rd_cnt>0` stalls until the cycle after the final outstanding R-last.

## Structure
- Package `axi_guard_pkg`: `RESP_OKAY=2'b00`, `RESP_DECERR=2'b11`, FSM state enums, and the `hit()` function.
- Sub-module `axi_wroute_fifo`: synchronous FIFO with full/empty flags and simultaneous push/pop allowed.

## Test plan
- Hit read at `0x8000_1000`, len=7 → AR forwarded in the same cycle; 8 downstream beats appear upstream unchanged, `rd_cnt` returns to 0.
- Miss read at `0x1000_0000`, len=3, id=5 → 4 beats, data 0, resp 3, id 5, last on beat 4; downstream AR stays idle.
- Two hit reads outstanding, then a miss AR → `ar_ready` stays 0 until the second R-last, then DECERR burst.
- Miss write len=1, id=2 → both W beats sunk, `io_out_w_valid` stays 0, then B resp 3 id 2; the next hit AW is blocked until the B handshake.
- 4 hit AWs with W withheld → 5th AW stalls (queue full); supplying W drains in order and the 5th is accepted the cycle after the first pop.
- Reset asserted during R_ERR beat 2 → next cycle `r_valid=0` and state idle; a subsequent hit read works normally.
